decode_buffer: RTL

DECODE_BUFFER -- requirements
Module: decode_buffer

---
 rtl/decode_buffer_pkg.sv | 38 +++
 rtl/decode_buffer_core.sv | 61 ++++++
 rtl/decode_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/decode_buffer_pkg.sv
// decode_buffer_pkg: shared opcodes, format codes, ALU constants and decoded-field record
package decode_buffer_pkg;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] F7_BASE      = 7'h00;
  localparam logic [6:0] F7_ALT       = 7'h20;
  localparam logic [6:0] F7_MULDIV    = 7'h01;
  localparam logic [2:0] F3_ADD       = 3'b000;
  localparam logic [2:0] F3_SLL       = 3'b001;
  localparam logic [2:0] F3_SR        = 3'b101;
  localparam logic [2:0] ALU_ADD      = 3'b000;
  typedef enum logic [2:0] {TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J} fmt_e;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic        is_load;
    logic        is_store;
    logic        is_writeback;
    logic        is_branch;
    logic        is_ja;
    logic        is_system;
    logic        is_sub;
    logic        is_mul;
    logic        illegal;
  } dec_t;
endpackage

// File: rtl/decode_buffer_core.sv
// decode_core: combinational RV32I(+M) field decoder
// inst_i: raw instruction; dec_o: decoded register fields, immediate, alu op and class flags
module decode_core
  import decode_buffer_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  fmt_e       fmt;
  logic       is_op;
  logic       op_ok;
  logic       sh_ok;
  logic       ill;
  logic       add_grp;
  always_comb begin
    opc = inst_i[6:0];
    f3 = inst_i[14:12];
    f7 = inst_i[31:25];
    is_op = opc == OPC_OP;
    fmt = (opc == OPC_LUI || opc == OPC_AUIPC) ? TYPE_U :
          opc == OPC_JAL    ? TYPE_J :
          opc == OPC_BRANCH ? TYPE_B :
          opc == OPC_STORE  ? TYPE_S :
          (opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_OP_IMM ||
           opc == OPC_SYSTEM || opc == OPC_MISC_MEM) ? TYPE_I : TYPE_R;
    op_ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) ||
            (EN_M && f7 == F7_MULDIV);
    // only the shift encodings of OP_IMM constrain funct7
    sh_ok = f3 == F3_SLL ? f7 == F7_BASE : f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
    ill = inst_i[1:0] != 2'b11 || (fmt == TYPE_R && !is_op) || (is_op && !op_ok) ||
          (opc == OPC_OP_IMM && !sh_ok);
    add_grp = fmt == TYPE_U || fmt == TYPE_J || fmt == TYPE_B || fmt == TYPE_S ||
              opc == OPC_JALR || opc == OPC_LOAD;
    dec_o = '0;
    dec_o.rs1 = inst_i[19:15];
    dec_o.rs2 = inst_i[24:20];
    dec_o.rd = inst_i[11:7];
    dec_o.imm = fmt == TYPE_I ? {{20{inst_i[31]}}, inst_i[31:20]} :
                fmt == TYPE_S ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
                fmt == TYPE_B ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
                fmt == TYPE_U ? {inst_i[31:12], 12'b0} :
                fmt == TYPE_J ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
                32'b0;
    dec_o.alu_op = add_grp ? ALU_ADD : f3;
    dec_o.is_load = !ill && opc == OPC_LOAD;
    dec_o.is_store = !ill && opc == OPC_STORE;
    dec_o.is_branch = !ill && opc == OPC_BRANCH;
    dec_o.is_ja = !ill && (opc == OPC_JAL || opc == OPC_JALR);
    dec_o.is_writeback = !ill && (fmt == TYPE_U || fmt == TYPE_J || is_op || opc == OPC_OP_IMM ||
                                  opc == OPC_JALR || opc == OPC_LOAD);
    dec_o.is_system = opc == OPC_SYSTEM;
    dec_o.is_sub = is_op && f7[5];
    dec_o.is_mul = !ill && EN_M && is_op && f7 == F7_MULDIV;
    dec_o.illegal = ill;
  end
endmodule

// File: rtl/decode_buffer.sv
// decode_buffer: DEPTH-entry {pc,inst} FIFO feeding one registered, decoded output slot
// fetch side: in_valid/in_ready/in_inst/in_pc; flush drops all held instructions
// execute side: out_valid/out_ready plus out_pc, out_inst and decoded out_* fields
// count: FIFO occupancy, not including the output slot
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit EN_M  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [31:0]                out_imm,
  output logic [2:0]                 out_alu_op,
  output logic                       out_is_load,
  output logic                       out_is_store,
  output logic                       out_is_writeback,
  output logic                       out_is_branch,
  output logic                       out_is_ja,
  output logic                       out_is_system,
  output logic                       out_is_sub,
  output logic                       out_is_mul,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [31:0]   pc_q, inst_q, src_pc, src_inst;
  dec_t          dec_q, dec;
  logic          push, slot_free, empty, bypass, fpush, fpop, load;
  decode_core #(.EN_M(EN_M)) u_dec (.inst_i(src_inst), .dec_o(dec));
  // in_ready depends only on state, flush and rst, never on out_ready
  assign in_ready = count_q < CW'(DEPTH) && !flush && !rst;
  always_comb begin
    push = in_valid && in_ready;
    slot_free = !valid_q || out_ready;
    empty = count_q == '0;
    bypass = push && empty && slot_free;
    fpop = !empty && slot_free;
    fpush = push && !bypass;
    load = !flush && (fpop || bypass);
    {src_pc, src_inst} = empty ? {in_pc, in_inst} : mem_q[rd_q];
    valid_d = flush ? 1'b0 : slot_free ? (fpop || bypass) : valid_q;
    count_d = flush ? '0 : count_q + CW'(fpush) - CW'(fpop);
    wr_d = flush ? '0 : fpush ? wr_q + PW'(1) : wr_q;
    rd_d = flush ? '0 : fpop ? rd_q + PW'(1) : rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      pc_q <= '0;
      inst_q <= '0;
      dec_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (load) begin
        pc_q <= src_pc;
        inst_q <= src_inst;
        dec_q <= dec;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (fpush) mem_q[wr_q] <= {in_pc, in_inst};
  end
  assign out_valid = valid_q;
  assign out_pc = pc_q;
  assign out_inst = inst_q;
  assign out_rs1 = dec_q.rs1;
  assign out_rs2 = dec_q.rs2;
  assign out_rd = dec_q.rd;
  assign out_imm = dec_q.imm;
  assign out_alu_op = dec_q.alu_op;
  assign out_is_load = dec_q.is_load;
  assign out_is_store = dec_q.is_store;
  assign out_is_writeback = dec_q.is_writeback;
  assign out_is_branch = dec_q.is_branch;
  assign out_is_ja = dec_q.is_ja;
  assign out_is_system = dec_q.is_system;
  assign out_is_sub = dec_q.is_sub;
  assign out_is_mul = dec_q.is_mul;
  assign out_illegal = dec_q.illegal;
  assign count = count_q;
endmodule
